// File: rtl/expr_arbiter_pkg.sv
// Shared constants and state encodings for the two-requester expression arbiter.
// Also holds small character-class helpers used by the recognizer.
package expr_arbiter_pkg;

    localparam logic [7:0] ASCII_0    = 8'd48;
    localparam logic [7:0] ASCII_9    = 8'd57;
    localparam logic [7:0] ASCII_PLUS = 8'd43;
    localparam logic [7:0] ASCII_STAR = 8'd42;

    typedef enum logic [1:0] {
        START   = 2'd0,
        DIGIT   = 2'd1,
        OP      = 2'd2,
        ILLEGAL = 2'd3
    } recog_state_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        REPORT = 2'd2
    } ctrl_state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        return (c == ASCII_PLUS) || (c == ASCII_STAR);
    endfunction

endpackage

// File: rtl/expr_recog.sv
// Recognizer for digit ((+|*) digit)*; advances one character per asserted step.
// sclr restarts the recognizer and wins over a simultaneous step.
module expr_recog
    import expr_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       sclr,
    input  logic       step,
    input  logic [7:0] in,
    output logic       accept
);

    recog_state_e state_q;
    recog_state_e state_d;

    // Next-state: ILLEGAL is absorbing until a restart
    always_comb begin
        state_d = state_q;
        if (sclr) begin
            state_d = START;
        end else if (step) begin
            case (state_q)
                START:   state_d = is_digit(in) ? DIGIT : ILLEGAL;
                DIGIT:   state_d = is_op(in)    ? OP    : ILLEGAL;
                OP:      state_d = is_digit(in) ? DIGIT : ILLEGAL;
                ILLEGAL: state_d = ILLEGAL;
                default: state_d = ILLEGAL;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= START;
        end else begin
            state_q <= state_d;
        end
    end

    assign accept = (state_q == DIGIT);

endmodule

// File: rtl/expr_arbiter.sv
// Round-robin sharing of one expression recognizer between two byte streams,
// granting whole strings and reporting one (id, accept, length) record per string.
module expr_arbiter
    import expr_arbiter_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             res_valid,
    output logic             res_id,
    output logic             res_accept,
    output logic [LEN_W-1:0] res_len,
    input  logic             res_ready
);

    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic             gnt_q;
    logic             gnt_d;
    logic             last_grant_q;
    logic             last_grant_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;

    logic             sclr_s;
    logic             step_s;
    logic             valid_s;
    logic             last_s;
    logic [7:0]       data_s;
    logic             accept_s;

    assign valid_s = gnt_q ? req1_valid : req0_valid;
    assign last_s  = gnt_q ? req1_last  : req0_last;
    assign data_s  = gnt_q ? req1_data  : req0_data;

    // Controller next-state, grant choice and length counting
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        sclr_s       = 1'b0;
        step_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // Contention goes to whoever was not served last
                    gnt_d   = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    len_d   = {LEN_W{1'b0}};
                    sclr_s  = 1'b1;
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (valid_s) begin
                    step_s  = 1'b1;
                    len_d   = (&len_q) ? len_q : len_q + {{(LEN_W-1){1'b0}}, 1'b1};
                    state_d = last_s ? REPORT : STREAM;
                end else begin
                    state_d = STREAM;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    last_grant_d = gnt_q;
                    state_d      = IDLE;
                end else begin
                    state_d = REPORT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            len_q        <= {LEN_W{1'b0}};
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
        end
    end

    expr_recog u_recog (
        .clk    (clk),
        .clr    (clr),
        .sclr   (sclr_s),
        .step   (step_s),
        .in     (data_s),
        .accept (accept_s)
    );

    assign req0_ready = (state_q == STREAM) && !gnt_q;
    assign req1_ready = (state_q == STREAM) &&  gnt_q;
    assign res_valid  = (state_q == REPORT);
    assign res_id     = (state_q == REPORT) && gnt_q;
    assign res_accept = (state_q == REPORT) && accept_s;
    assign res_len    = (state_q == REPORT) ? len_q : {LEN_W{1'b0}};

endmodule

// File: tb/tb_expr_arbiter.sv
// Randomized and directed bench for expr_arbiter against a positional grammar model;
// a second instance with LEN_W=2 runs in lockstep to observe length saturation.
module tb_expr_arbiter;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       r0v = 1'b0, r0l = 1'b0, r1v = 1'b0, r1l = 1'b0;
    logic [7:0] r0d = 8'd0, r1d = 8'd0;
    logic       res_ready = 1'b0;

    logic       req0_ready, req1_ready, res_valid, res_id, res_accept;
    logic [7:0] res_len;
    logic       s_req0_ready, s_req1_ready, s_res_valid, s_res_id, s_res_accept;
    logic [1:0] s_res_len;

    int errors = 0;
    int checks = 0;
    int rdy0_cnt = 0;
    int both_cnt = 0;
    bit done = 1'b0;

    typedef struct { bit id; bit acc; int len; int len2; } rec_t;
    rec_t got[$];

    always #5 clk = ~clk;

    expr_arbiter #(.LEN_W(8)) dut (
        .clk(clk), .clr(clr),
        .req0_valid(r0v), .req0_data(r0d), .req0_last(r0l), .req0_ready(req0_ready),
        .req1_valid(r1v), .req1_data(r1d), .req1_last(r1l), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_id(res_id), .res_accept(res_accept),
        .res_len(res_len), .res_ready(res_ready)
    );

    expr_arbiter #(.LEN_W(2)) dut_sat (
        .clk(clk), .clr(clr),
        .req0_valid(r0v), .req0_data(r0d), .req0_last(r0l), .req0_ready(s_req0_ready),
        .req1_valid(r1v), .req1_data(r1d), .req1_last(r1l), .req1_ready(s_req1_ready),
        .res_valid(s_res_valid), .res_id(s_res_id), .res_accept(s_res_accept),
        .res_len(s_res_len), .res_ready(res_ready)
    );

    // Capture records at the handshake and count ready activity
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            rec_t r;
            r.id   = res_id;
            r.acc  = res_accept;
            r.len  = int'(res_len);
            r.len2 = s_res_valid ? int'(s_res_len) : -1;
            got.push_back(r);
        end
        if (req0_ready) rdy0_cnt++;
        if (req0_ready && req1_ready) both_cnt++;
    end

    // Grammar model: odd length, digits at even positions, operators at odd ones
    function automatic bit model_accept(input string s);
        if (s.len() % 2 == 0) return 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            c = s[i];
            if (i % 2 == 0) begin
                if (c < 8'd48 || c > 8'd57) return 1'b0;
            end else begin
                if (c != 8'd43 && c != 8'd42) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic string gen_str();
        int n;
        bit good;
        string s;
        n = $urandom_range(1, 6);
        good = $urandom_range(0, 1) == 1;
        s = "";
        for (int i = 0; i < n; i++) begin
            logic [7:0] c;
            int p;
            p = $urandom_range(0, 9);
            if (good) c = (i % 2 == 0) ? 8'(48 + $urandom_range(0, 9)) : ($urandom_range(0, 1) == 1 ? 8'd43 : 8'd42);
            else if (p < 6) c = 8'(48 + $urandom_range(0, 9));
            else if (p == 6) c = 8'd43;
            else if (p == 7) c = 8'd42;
            else if (p == 8) c = 8'd120;
            else c = 8'd32;
            s = $sformatf("%s%c", s, c);
        end
        return s;
    endfunction

    task automatic send(input int id, input string s, input bit with_last, input int max_gap);
        for (int i = 0; i < s.len(); i++) begin
            int t;
            int g;
            logic [7:0] c;
            bit l;
            t = 0;
            c = s[i];
            l = with_last && (i == s.len() - 1);
            if (id == 0) begin r0v = 1'b1; r0d = c; r0l = l; end
            else begin r1v = 1'b1; r1d = c; r1l = l; end
            while (t < 400) begin
                @(negedge clk);
                if ((id == 0) ? req0_ready : req1_ready) break;
                t++;
            end
            checks++;
            if (t >= 400) begin
                errors++;
                $display("FAIL send_ready: id=%0d byte=%0d ready=0 required=1", id, i);
            end
            @(posedge clk); #1;
            if (id == 0) begin r0v = 1'b0; r0l = 1'b0; end
            else begin r1v = 1'b0; r1l = 1'b0; end
            g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_records(input int n, input string name);
        int t;
        t = 0;
        while (got.size() < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (got.size() < n) begin
            errors++;
            $display("FAIL %s_records: got=%0d required=%0d", name, got.size(), n);
        end
    endtask

    task automatic test_reset();
        #2 clr = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, res_valid, res_id, res_accept, res_len,
             s_req0_ready, s_req1_ready, s_res_valid, s_res_len} !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: r0rdy=%b r1rdy=%b vld=%b id=%b acc=%b len=%0d required all 0",
                     req0_ready, req1_ready, res_valid, res_id, res_accept, res_len);
        end
        @(posedge clk); #1 clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, res_valid} !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: r0rdy=%b r1rdy=%b vld=%b required 0", req0_ready, req1_ready, res_valid);
        end
    endtask

    task automatic test_basic();
        int base;
        got.delete();
        res_ready = 1'b1;
        base = rdy0_cnt;
        send(0, "1+2", 1'b1, 0);
        wait_records(1, "basic");
        repeat (2) @(negedge clk);
        checks++;
        if (rdy0_cnt - base != 3) begin
            errors++;
            $display("FAIL basic_ready_cycles: got=%0d required=3", rdy0_cnt - base);
        end
        checks++;
        if (got.size() != 1 || got[0].id !== 1'b0 || got[0].acc !== 1'b1 || got[0].len != 3) begin
            errors++;
            $display("FAIL basic_record: n=%0d id=%0d acc=%0d len=%0d required n=1 id=0 acc=1 len=3",
                     got.size(), got[0].id, got[0].acc, got[0].len);
        end
    endtask

    task automatic test_illegal();
        got.delete();
        send(1, "1+", 1'b1, 0);
        send(1, "12", 1'b1, 0);
        wait_records(2, "illegal");
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got[i].id !== 1'b1 || got[i].acc !== 1'b0 || got[i].len != 2) begin
                errors++;
                $display("FAIL illegal_record%0d: id=%0d acc=%0d len=%0d required id=1 acc=0 len=2",
                         i, got[i].id, got[i].acc, got[i].len);
            end
        end
    endtask

    task automatic test_round_robin();
        int base;
        got.delete();
        base = both_cnt;
        fork
            begin send(0, "3*4", 1'b1, 0); send(0, "3*4", 1'b1, 0); end
            begin send(1, "3*4", 1'b1, 0); send(1, "3*4", 1'b1, 0); end
        join
        wait_records(4, "rr");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i].id !== 1'(i % 2) || got[i].acc !== 1'b1 || got[i].len != 3) begin
                errors++;
                $display("FAIL rr_record%0d: id=%0d acc=%0d len=%0d required id=%0d acc=1 len=3",
                         i, got[i].id, got[i].acc, got[i].len, i % 2);
            end
        end
        checks++;
        if (both_cnt != base) begin
            errors++;
            $display("FAIL rr_both_ready: cycles=%0d required=0", both_cnt - base);
        end
    endtask

    task automatic test_backpressure();
        int t;
        got.delete();
        res_ready = 1'b0;
        send(0, "9", 1'b1, 0);
        t = 0;
        while (!res_valid && t < 50) begin @(negedge clk); t++; end
        r1v = 1'b1; r1d = 8'd50; r1l = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_id !== 1'b0 || res_accept !== 1'b1 || res_len !== 8'd1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b id=%b acc=%b len=%0d r0rdy=%b r1rdy=%b required 1 0 1 1 0 0",
                         i, res_valid, res_id, res_accept, res_len, req0_ready, req1_ready);
            end
        end
        res_ready = 1'b1;
        send(1, "2", 1'b1, 0);
        wait_records(2, "bp");
        checks++;
        if (got[0].id !== 1'b0 || got[0].acc !== 1'b1 || got[0].len != 1 ||
            got[1].id !== 1'b1 || got[1].acc !== 1'b1 || got[1].len != 1) begin
            errors++;
            $display("FAIL bp_records: id=%0d/%0d acc=%0d/%0d len=%0d/%0d required 0/1 1/1 1/1",
                     got[0].id, got[1].id, got[0].acc, got[1].acc, got[0].len, got[1].len);
        end
    endtask

    task automatic test_clr_abort();
        got.delete();
        res_ready = 1'b1;
        send(0, "5+", 1'b0, 0);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_pre_stream: r0rdy=%b required=1", req0_ready);
        end
        clr = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, res_valid, res_id, res_accept, res_len} !== 13'd0) begin
            errors++;
            $display("FAIL clr_async: r0rdy=%b r1rdy=%b vld=%b len=%0d required all 0",
                     req0_ready, req1_ready, res_valid, res_len);
        end
        @(posedge clk); #1 clr = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (got.size() != 0) begin
            errors++;
            $display("FAIL clr_no_record: got=%0d required=0", got.size());
        end
        send(0, "5+6", 1'b1, 0);
        wait_records(1, "clr");
        checks++;
        if (got[0].id !== 1'b0 || got[0].acc !== 1'b1 || got[0].len != 3) begin
            errors++;
            $display("FAIL clr_resend: id=%0d acc=%0d len=%0d required id=0 acc=1 len=3",
                     got[0].id, got[0].acc, got[0].len);
        end
    endtask

    task automatic test_saturation();
        got.delete();
        send(0, "1+2+3", 1'b1, 0);
        wait_records(1, "sat");
        checks++;
        if (got[0].acc !== 1'b1 || got[0].len != 5 || got[0].len2 != 3) begin
            errors++;
            $display("FAIL sat_record: acc=%0d len=%0d len2=%0d required acc=1 len=5 len2=3",
                     got[0].acc, got[0].len, got[0].len2);
        end
    endtask

    task automatic test_random();
        string s0[8];
        string s1[8];
        int i0, i1;
        for (int i = 0; i < 8; i++) begin
            s0[i] = gen_str();
            s1[i] = gen_str();
        end
        got.delete();
        done = 1'b0;
        fork
            begin
                fork
                    begin for (int i = 0; i < 8; i++) send(0, s0[i], 1'b1, 2); end
                    begin for (int i = 0; i < 8; i++) send(1, s1[i], 1'b1, 2); end
                join
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    res_ready = ($urandom_range(0, 1) == 1);
                end
                res_ready = 1'b1;
            end
        join
        wait_records(16, "rand");
        i0 = 0;
        i1 = 0;
        foreach (got[k]) begin
            string s;
            if (got[k].id == 1'b0) begin s = (i0 < 8) ? s0[i0] : ""; i0++; end
            else begin s = (i1 < 8) ? s1[i1] : ""; i1++; end
            checks++;
            if (got[k].acc !== model_accept(s) || got[k].len != s.len() || got[k].len2 != sat(s.len(), 3)) begin
                errors++;
                $display("FAIL rand_record%0d: id=%0d str=\"%s\" acc=%0d len=%0d len2=%0d required acc=%0d len=%0d len2=%0d",
                         k, got[k].id, s, got[k].acc, got[k].len, got[k].len2,
                         model_accept(s), s.len(), sat(s.len(), 3));
            end
        end
        checks++;
        if (i0 != 8 || i1 != 8) begin
            errors++;
            $display("FAIL rand_counts: id0=%0d id1=%0d required 8 8", i0, i1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_round_robin();
        test_backpressure();
        test_clr_abort();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/expr_arbiter.md
Name: expr_arbiter

Overview:
- Shares one expression recognizer between two byte-stream requesters.
- Grammar: digit ((+|*) digit)*, ASCII.
- Arbitration is round-robin at whole-string granularity: a granted string runs to completion before any switch.
- Each string gets a clean recognizer start; one verdict record (id, accept, length) is reported per string.
- Sits between the input character sources and downstream result consumers.

Parameters:
- LEN_W, 8, width of the string-length counter in the result; the count saturates at 2^LEN_W-1.

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 byte valid
- req0_data  in  8  requester 0 ASCII byte
- req0_last  in  1  requester 0: this byte ends the string
- req0_ready  out  1  requester 0 byte accepted when valid&ready
- req1_valid  in  1  requester 1 byte valid
- req1_data  in  8  requester 1 ASCII byte
- req1_last  in  1  requester 1: this byte ends the string
- req1_ready  out  1  requester 1 byte accepted when valid&ready
- res_valid  out  1  result record valid
- res_id  out  1  requester index of the reported string
- res_accept  out  1  1 = string matches the grammar
- res_len  out  LEN_W  bytes in the string, saturating
- res_ready  in  1  consumer takes the record when valid&ready

Behaviour:
- Reset (clr high, asynchronous):
  - Controller state = IDLE; recognizer = START.
  - last_grant = 1, so requester 0 wins first.
  - req0_ready = req1_ready = res_valid = res_id = res_accept = res_len = 0.
- Controller FSM has three states: IDLE, STREAM, REPORT.
- IDLE:
  - All ready outputs = 0.
  - If any reqN_valid: grant = the valid requester. If both are valid, grant = ~last_grant.
  - On grant, the registered gnt is set, the length counter goes to 0, a synchronous clear is pulsed to the recognizer, and the FSM goes to STREAM next cycle.
  - No bytes are consumed in IDLE; grant to first possible accept is 1 cycle.
- STREAM:
  - req[gnt]_ready = 1; the other requester's ready = 0.
  - Each handshake cycle: the recognizer steps on data, and len increments, saturating at all-ones.
  - Cycles where valid is low: no state change.
  - Handshake with last=1: go to REPORT next cycle.
  - Data of the non-granted requester is ignored and never consumed.
- REPORT:
  - res_valid = 1.
  - res_id = gnt.
  - res_accept = (recognizer state == DIGIT), evaluated after the last byte.
  - res_len = counter.
  - Outputs are held stable while res_ready = 0.
  - On res_valid & res_ready: last_grant <= gnt, go to IDLE, res_valid drops next cycle.
- Minimum per-string overhead: 1 IDLE cycle + 1 REPORT cycle.
- Recognizer states: START, DIGIT, OP, ILLEGAL.
  - START --digit('0'..'9', 48..57)--> DIGIT; any other byte --> ILLEGAL.
  - DIGIT --'+'(43) or '*'(42)--> OP; any other byte --> ILLEGAL. Two consecutive digits are illegal.
  - OP --digit--> DIGIT; any other byte --> ILLEGAL.
  - ILLEGAL is absorbing until the sync clear or clr.
- Boundaries:
  - A single-byte string with last=1 is legal; "7" gives accept=1, len=1.
  - A string ending in an operator is rejected.
  - Empty strings do not exist; last always comes with a byte.
  - clr mid-STREAM or mid-REPORT aborts the string. No result is produced, and the requester must restart the string.
  - A requester that drops valid mid-string stalls the controller; there is no timeout.
  - Only one requester valid: it is granted regardless of last_grant.
  - res_len saturation does not affect res_accept.

Decomposition:
- Shared package holds:
  - Constants ASCII_0=48, ASCII_9=57, ASCII_PLUS=43, ASCII_STAR=42.
  - Recognizer state encodings START, DIGIT, OP, ILLEGAL.
  - Controller state encodings IDLE, STREAM, REPORT.
- Natural sub-module: expr_recog (ports clk, clr, sclr, step, in[7:0], accept).
  - One step per asserted step.
  - sclr has priority over step.
- expr_arbiter instantiates it once and contains the grant/length/report logic.

Test Plan:
- req0 sends '1','+','2' (last on '2'), res_ready=1 -> one record id=0 accept=1 len=3; req0_ready high exactly during the 3 STREAM cycles.
- req1 sends "1+" then "12" -> records id=1 accept=0 len=2, then id=1 accept=0 len=2; ILLEGAL is reached on the second '2' and is absorbing.
- Both requesters valid continuously, each sending "3*4" -> results in order id=0,1,0,1, all accept=1 len=3; the non-granted ready stays 0.
- res_ready held low 5 cycles in REPORT -> res_valid, res_id, res_accept, res_len stable for all 5 cycles; neither ready asserts; the next grant happens only after the handshake.
- clr pulsed after 2 bytes of "5+6" on req0 -> all outputs 0 asynchronously, no record; a resent "5+6" yields accept=1 len=3.
- LEN_W=2 with "1+2+3" (5 bytes) -> res_len=3 (saturated), accept=1.
